// File: rtl/fxp_pkg.sv
// Shared fixed-point types, defaults and helpers for the signal engine and other fixed-point users.
// Latency: none (types, constants and combinational functions only).
// Backpressure: n/a. Optional feature macro FXP_SAT_EN selects saturating fxp_mul_q.
package fxp_pkg;

  localparam int FXP_W               = 32;
  localparam int FXP_FRAC            = 16;
  localparam int FXP_DEF_ALPHA_SHIFT = 5;

  typedef logic signed [FXP_W-1:0] fxp_t;

  localparam fxp_t FXP_DEF_LIMIT = fxp_t'(64'd2 << FXP_FRAC);
  localparam fxp_t FXP_MAX       = {1'b0, {(FXP_W-1){1'b1}}};
  localparam fxp_t FXP_MIN       = {1'b1, {(FXP_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } fxp_state_e;

  // Clamp a double-width value into fxp_t; it fits when all bits above the
  // result's sign bit agree with it.
  function automatic fxp_t fxp_sat(input logic signed [2*FXP_W-1:0] v);
    if ((&v[2*FXP_W-1:FXP_W-1]) || !(|v[2*FXP_W-1:FXP_W-1])) begin
      return fxp_t'(v);
    end
    return v[2*FXP_W-1] ? FXP_MIN : FXP_MAX;
  endfunction

  // Q-format multiply: full product, rescale by FXP_FRAC, then clamp or wrap.
  function automatic fxp_t fxp_mul_q(input fxp_t a, input fxp_t b);
    logic signed [2*FXP_W-1:0] ax, bx, p;
    ax = {{FXP_W{a[FXP_W-1]}}, a};
    bx = {{FXP_W{b[FXP_W-1]}}, b};
    p  = (ax * bx) >>> FXP_FRAC;
`ifdef FXP_SAT_EN
    return fxp_sat(p);
`else
    return fxp_t'(p);
`endif
  endfunction

endpackage

// File: rtl/fxp_mac_unit.sv
// Combinational Q-format multiply-accumulate: acc_next = acc + mulq(weight, sample).
// Latency: 0 cycles (purely combinational, shared across channels by the engine).
// Backpressure: none; FXP_SAT_EN clamps the product and the add, otherwise both wrap.
module fxp_mac_unit #(
  parameter int DATA_W = 32,
  parameter int FRAC   = 16
) (
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] acc,
  output logic signed [DATA_W-1:0] acc_next
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [PW-1:0]     w_ext;
  logic signed [PW-1:0]     s_ext;
  logic signed [PW-1:0]     prod_sh;
  logic signed [DATA_W-1:0] term;
  logic signed [DATA_W:0]   sum;

  // Rescaled product reduced to DATA_W, then one guard bit for the accumulate.
  always_comb begin
    w_ext   = {{DATA_W{weight[DATA_W-1]}}, weight};
    s_ext   = {{DATA_W{sample[DATA_W-1]}}, sample};
    prod_sh = (w_ext * s_ext) >>> FRAC;
`ifdef FXP_SAT_EN
    if ((&prod_sh[PW-1:DATA_W-1]) || !(|prod_sh[PW-1:DATA_W-1])) begin
      term = DATA_W'(prod_sh);
    end else begin
      term = prod_sh[PW-1] ? Q_MIN : Q_MAX;
    end
`else
    term = DATA_W'(prod_sh);
`endif
    sum = {acc[DATA_W-1], acc} + {term[DATA_W-1], term};
`ifdef FXP_SAT_EN
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      acc_next = sum[DATA_W] ? Q_MIN : Q_MAX;
    end else begin
      acc_next = DATA_W'(sum);
    end
`else
    acc_next = DATA_W'(sum);
`endif
  end

endmodule

// File: rtl/fxp_signal_engine.sv
// Multi-channel EMA + weighted score engine with a programmable |score| > limit risk flag.
// Latency: NCH cycles from acceptance to out_valid; one transaction per NCH+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Macro FXP_SAT_EN.
module fxp_signal_engine
  import fxp_pkg::*;
#(
  parameter int DATA_W      = FXP_W,
  parameter int FRAC        = FXP_FRAC,
  parameter int NCH         = 4,
  parameter int ALPHA_SHIFT = FXP_DEF_ALPHA_SHIFT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NCH*DATA_W-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_score,
  output logic                       out_risk,
  input  logic                       cfg_we,
  input  logic [$clog2(NCH+1)-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]          cfg_wdata,
  output logic                       busy
);

  localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);
  localparam logic signed [DATA_W-1:0] W_RST   = DATA_W'((64'd1 << FRAC) / 64'(NCH));
  localparam logic signed [DATA_W-1:0] LIM_RST = DATA_W'(64'd2 << FRAC);
  localparam logic signed [DATA_W-1:0] Q_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] Q_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  fxp_state_e state_q, state_d;
  logic [KW-1:0]            k_q;
  logic signed [DATA_W-1:0] x_q   [NCH];
  logic signed [DATA_W-1:0] ema_q [NCH];
  logic signed [DATA_W-1:0] w_q   [NCH];
  logic signed [DATA_W-1:0] limit_q;
  logic signed [DATA_W-1:0] acc_q;
  logic                     primed_q;
  logic [DATA_W-1:0]        score_q;
  logic                     risk_q;

  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W:0]   ema_sum;
  logic signed [DATA_W-1:0] ema_new;
  logic signed [DATA_W-1:0] acc_next;
  logic signed [DATA_W-1:0] score_abs;

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_score = score_q;
  assign out_risk  = risk_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept in IDLE, walk NCH channels, hold the result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid)        state_d = ST_UPDATE;
      ST_UPDATE: if (k_q == K_LAST)   state_d = ST_DONE;
      ST_DONE:   if (out_ready)       state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // EMA step for the current channel; the difference gets a guard bit so the
  // shifted step plus the old EMA always lands back inside DATA_W.
  always_comb begin
    diff    = {x_q[k_q][DATA_W-1], x_q[k_q]} - {ema_q[k_q][DATA_W-1], ema_q[k_q]};
    ema_sum = {ema_q[k_q][DATA_W-1], ema_q[k_q]} + (diff >>> ALPHA_SHIFT);
    ema_new = primed_q ? DATA_W'(ema_sum) : x_q[k_q];
  end

  fxp_mac_unit #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC)
  ) u_mac (
    .weight   (w_q[k_q]),
    .sample   (ema_new),
    .acc      (acc_q),
    .acc_next (acc_next)
  );

  // Magnitude of the final score; most-negative either wraps onto itself or clamps.
  always_comb begin
    score_abs = acc_next[DATA_W-1] ? -acc_next : acc_next;
`ifdef FXP_SAT_EN
    if (acc_next == Q_MIN) score_abs = Q_MAX;
`endif
  end

  // Datapath: config and sample capture in IDLE, per-channel update, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      limit_q  <= LIM_RST;
      acc_q    <= '0;
      primed_q <= 1'b0;
      score_q  <= '0;
      risk_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        x_q[i]   <= '0;
        ema_q[i] <= '0;
        w_q[i]   <= W_RST;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_we) begin
            for (int i = 0; i < NCH; i++) begin
              if (int'(cfg_addr) == i) w_q[i] <= cfg_wdata;
            end
            if (int'(cfg_addr) == NCH) limit_q <= cfg_wdata;
          end
          if (in_valid) begin
            for (int i = 0; i < NCH; i++) x_q[i] <= in_data[i*DATA_W +: DATA_W];
            acc_q <= '0;
            k_q   <= '0;
          end
        end
        ST_UPDATE: begin
          ema_q[k_q] <= ema_new;
          acc_q      <= acc_next;
          k_q        <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            score_q  <= acc_next;
            risk_q   <= (score_abs > limit_q);
            primed_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_signal_engine.sv
// Directed bench for fxp_signal_engine: vector table plus backpressure, reset and saturation sequences.
// Latency: expects out_valid NCH=4 cycles after acceptance.
// Backpressure: exercises out_ready=0 holds; expectations follow FXP_SAT_EN when defined.
module tb_fxp_signal_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_score;
  logic         out_risk;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_addr = '0;
  logic [31:0]  cfg_wdata = '0;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  fxp_signal_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_score (out_score),
    .out_risk  (out_risk),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cfg;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] x;
    logic [31:0] score;
    logic        risk;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] x3, input logic [31:0] x2,
                      input logic [31:0] x1, input logic [31:0] x0);
    in_data  = {x3, x2, x1, x0};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] sat_exp;

    tbl[0] = '{1'b1, 1'b0, 3'd0, 32'd0,      32'd65536,    32'd65536,    1'b0};
    tbl[1] = '{1'b0, 1'b0, 3'd0, 32'd0,      32'd196608,   32'd69632,    1'b0};
    tbl[2] = '{1'b1, 1'b0, 3'd0, 32'd0,      32'd131072,   32'd131072,   1'b0};
    tbl[3] = '{1'b1, 1'b0, 3'd0, 32'd0,      32'hFFFF0000, 32'hFFFF0000, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 3'd0, 32'd0,      32'd65536,    32'd65536,    1'b0};
    tbl[5] = '{1'b0, 1'b1, 3'd0, 32'd262144, 32'd65536,    32'd311296,   1'b1};
    tbl[6] = '{1'b0, 1'b1, 3'd4, 32'd393216, 32'd65536,    32'd311296,   1'b0};
    tbl[7] = '{1'b0, 1'b1, 3'd5, 32'd0,      32'd65536,    32'd311296,   1'b0};

    #2;
    check("reset outputs", {out_valid, in_ready, busy, out_risk, out_score},
          {1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst) do_reset();
      if (tbl[i].cfg) cfg_write(tbl[i].addr, tbl[i].wdata);
      send(tbl[i].x, tbl[i].x, tbl[i].x, tbl[i].x);
      wait_out(n);
      check($sformatf("v%0d latency", i), 64'(n), 64'd4);
      check($sformatf("v%0d score", i), 64'(out_score), 64'(tbl[i].score));
      check($sformatf("v%0d risk", i), 64'(out_risk), 64'(tbl[i].risk));
      @(posedge clk);
      #1;
    end

    // Backpressure: result held, input and config writes ignored while in DONE.
    out_ready = 1'b0;
    send(32'd65536, 32'd65536, 32'd65536, 32'd65536);
    wait_out(n);
    check("bp latency", 64'(n), 64'd4);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = {4{32'h00050000}};
      cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 32'h00100000;
      @(posedge clk);
      #1;
      check($sformatf("bp hold c%0d", c), {out_valid, in_ready, out_risk, out_score},
            {1'b1, 1'b0, 1'b0, 32'd311296});
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release", {out_valid, in_ready}, {1'b0, 1'b1});
    send(32'd65536, 32'd65536, 32'd65536, 32'd65536);
    wait_out(n);
    check("bp after score", 64'(out_score), 64'd311296);
    @(posedge clk);
    #1;

    // Reset in the middle of UPDATE: everything back to reset values, history lost.
    send(32'd65536, 32'd65536, 32'd65536, 32'd65536);
    @(posedge clk);
    #1;
    check("mid busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset outputs", {out_valid, in_ready, busy, out_risk, out_score},
          {1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(32'd196608, 32'd196608, 32'd196608, 32'd196608);
    wait_out(n);
    check("post reset score", 64'(out_score), 64'd196608);
    check("post reset risk", 64'(out_risk), 64'd1);
    @(posedge clk);
    #1;

    // Product overflow on channel 0.
`ifdef FXP_SAT_EN
    sat_exp = 32'h7FFFFFFF;
`else
    sat_exp = 32'h7FFF8001;
`endif
    do_reset();
    cfg_write(3'd0, 32'h7FFFFFFF);
    cfg_write(3'd1, 32'd0);
    cfg_write(3'd2, 32'd0);
    cfg_write(3'd3, 32'd0);
    send(32'd0, 32'd0, 32'd0, 32'h7FFF0000);
    wait_out(n);
    check("sat latency", 64'(n), 64'd4);
    check("sat score", 64'(out_score), 64'(sat_exp));
    check("sat risk", 64'(out_risk), 64'd1);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fxp_signal_engine.md
# fxp_signal_engine

Parametrised multi-channel fixed-point signal engine: accepts a vector of NCH signed fixed-point samples per transaction, updates one exponential moving average (EMA) per channel, and forms a weighted score from the EMAs. It compares the score against a programmable risk limit and returns the score and a risk flag over a valid/ready handshake. It generalises the fixed two-signal, compile-time-weight scheme to N channels, runtime-programmable weights and limit, EMA priming, and optional saturating arithmetic. It sits between the market-data sample front end and the risk/decision logic.

## Interface
- DATA_W, 32: sample, weight, EMA and score width, signed two's complement.
- FRAC, 16: fractional bits (Q(DATA_W-FRAC).FRAC).
- NCH, 4: channel count, 1..16.
- ALPHA_SHIFT, 5: EMA alpha = 2^-ALPHA_SHIFT.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample vector valid.
- in_ready  out  1  engine can accept; high only in IDLE.
- in_data  in  NCH*DATA_W  samples; channel k at bits [k*DATA_W +: DATA_W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_score  out  DATA_W  weighted score.
- out_risk  out  1  |score| > limit.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  $clog2(NCH+1)  0..NCH-1 select weight k; NCH selects limit.
- cfg_wdata  in  DATA_W  value written.
- busy  out  1  high when state != IDLE.

## Operation
- FSM: IDLE -> UPDATE on in_valid&&in_ready; UPDATE runs NCH cycles, index k=0..NCH-1; UPDATE -> DONE after k=NCH-1; DONE -> IDLE on out_valid&&out_ready.
- Accept edge: latch in_data; clear the accumulator; k=0.
- Each UPDATE edge, channel k:
  - If primed=0: ema_new = x[k]; else ema_new = ema[k] + ((x[k]-ema[k]) >>> ALPHA_SHIFT).
  - The subtraction is done in DATA_W+1 bits, shifted arithmetically, then added back; the result always fits DATA_W.
  - ema[k] <= ema_new; acc <= acc + mulq(W[k], ema_new).
- mulq: full 2*DATA_W signed product, arithmetic shift right by FRAC, reduced to DATA_W (see Configuration).
- Entry to DONE: out_score <= final acc; out_risk <= abs(score) > limit (strict, signed). primed is set to 1 after the first completed UPDATE.
- abs(most-negative) wraps to most-negative without FXP_SAT_EN, so out_risk=0 for it; with FXP_SAT_EN it becomes the maximum positive value.
- Config writes take effect only in IDLE. In UPDATE or DONE they are ignored silently. A cfg_addr above NCH is ignored.
- Reset values: ema all 0; primed 0; W[k] = (1<<FRAC)/NCH truncated; limit = 2<<FRAC; acc 0; state IDLE; out_valid 0; out_score 0; out_risk 0; in_ready 1; busy 0.
- Reset mid-operation: all state returns to reset values immediately; the partial result is discarded; the EMA history is lost.

## Timing
- Acceptance at edge T; UPDATE edges T+1..T+NCH; out_valid is high after edge T+NCH. Latency is NCH cycles.
- out_score and out_risk are stable while out_valid=1 && out_ready=0.
- in_ready=0 from edge T until the edge where the DONE handshake completes. No new sample is accepted in the same cycle as out handshake.
- Throughput: one transaction per NCH+2 cycles with out_ready held high.
- A config write and an in_valid acceptance in the same IDLE cycle: the write lands first, so the new weight or limit is used by that transaction.

## Configuration
- FXP_SAT_EN defined: mulq result and every accumulator add clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; abs saturates.
- FXP_SAT_EN undefined: truncate to the low DATA_W bits (wrap).

## Structure
- fxp_pkg holds the following, shared with existing fixed-point users:
  - typedef fxp_t (signed DATA_W), default ALPHA_SHIFT and default limit constants.
  - Functions fxp_sat (2*DATA_W to DATA_W clamp) and fxp_mul_q (honours FXP_SAT_EN).
- One sub-module, fxp_mac_unit: combinational mulq plus accumulate, with the saturation option; instantiated once and shared across channels.

## Test plan
Defaults: NCH=4, FRAC=16, ALPHA_SHIFT=5.
- Reset: assert rst_n=0 mid-UPDATE -> out_valid=0, in_ready=1, busy=0, out_score=0, out_risk=0.
- Priming: first sample with all x=65536 -> each ema=65536, score=65536, risk=0, out_valid 4 cycles after acceptance.
- EMA step: next sample with all x=196608 -> each ema=69632, score=69632, risk=0.
- Weights/limit: in IDLE after priming at 65536, write W0=262144 -> next all-65536 sample gives score=311296, risk=1; then write limit=393216 -> risk=0.
- Backpressure: out_ready=0 for 10 cycles -> outputs held, in_valid ignored, cfg_we to W1 ignored (next score unchanged).
- Saturation: W0=0x7FFFFFFF, W1..3=0, primed x0=0x7FFF0000 -> with FXP_SAT_EN score=0x7FFFFFFF, risk=1; without it, score equals the wrapped low 32 bits of the shifted product.
